// File: rtl/burst_accumulator_pkg.sv
// Shared types and default sizing for the burst accumulator.
package burst_accumulator_pkg;

  localparam int unsigned WIDTH_DEFAULT   = 8;
  localparam int unsigned COUNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/burst_accumulator_if.sv
// Control, operand stream and result stream of the burst accumulator.
interface burst_accumulator_if
  import burst_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) ();

  logic               start;
  logic [COUNT_W-1:0] len;
  logic               abort;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_ovf;
  logic               busy;

  modport master (
    output start, len, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  start, len, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

endinterface

// File: rtl/burst_accumulator_accum_add_stage.sv
// Combinational WIDTH-bit adder returning the sum and its carry-out.
module accum_add_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/burst_accumulator.sv
// Sums a programmed-length burst of operands and presents one result word.
// Build option: BURST_ACCUM_SATURATE_EN clamps the sum to all-ones on carry-out.
module burst_accumulator
  import burst_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  burst_accumulator_if.slave  bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic               ovf_q,   ovf_d;
  logic [COUNT_W-1:0] rem_q,   rem_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;

  accum_add_stage #(.WIDTH(WIDTH)) u_add (
    .a     (acc_q),
    .b     (bus.in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = bus.len;
          state_d = (bus.len != '0) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone is the handshake
        if (bus.in_valid) begin
`ifdef BURST_ACCUM_SATURATE_EN
          acc_d = (add_carry || ovf_q) ? {WIDTH{1'b1}} : add_sum;
`else
          acc_d = add_sum;
`endif
          ovf_d = ovf_q | add_carry;
          rem_d = rem_q - COUNT_W'(1);
          if (rem_q == COUNT_W'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything: discard this cycle's updates entirely
    if (bus.abort) begin
      state_d = IDLE;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      rem_d   = rem_q;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = (state_q == HOLD) ? acc_q : '0;
  assign bus.out_ovf   = (state_q == HOLD) ? ovf_q : 1'b0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_burst_accumulator.sv
// Directed self-checking bench for burst_accumulator (8-bit operands and length).
module tb_burst_accumulator;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  burst_accumulator_if #(.WIDTH(8), .COUNT_W(8)) bus ();

  burst_accumulator #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Reset state
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_out_ovf",   32'(bus.out_ovf),   0);
    chk("rst_busy",      32'(bus.busy),      0);
    rst_n = 1'b1;
    tick();

    // len=3: 10+20+30, back-to-back
    bus.start = 1'b1; bus.len = 8'd3;
    tick();
    $display("burst len=3 started");
    chk("b1_in_ready_after_start", 32'(bus.in_ready), 1);
    chk("b1_busy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd10; tick();
    bus.in_data = 8'd20; tick();
    chk("b1_no_early_valid", 32'(bus.out_valid), 0);
    bus.in_data = 8'd30; tick();
    bus.in_valid = 1'b0;
    chk("b1_out_valid", 32'(bus.out_valid), 1);
    chk("b1_out_data",  32'(bus.out_data),  60);
    chk("b1_out_ovf",   32'(bus.out_ovf),   0);
    chk("b1_in_ready_hold", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;
    $display("burst len=3 result consumed");
    chk("b1_idle_valid", 32'(bus.out_valid), 0);
    chk("b1_idle_busy",  32'(bus.busy),      0);

    // len=2: 200+100 overflows
    bus.start = 1'b1; bus.len = 8'd2; tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd200; tick();
    bus.in_data = 8'd100; tick();
    bus.in_valid = 1'b0;
    $display("burst 200+100 result data=%0d ovf=%0d", bus.out_data, bus.out_ovf);
    chk("ovf_out_valid", 32'(bus.out_valid), 1);
`ifdef BURST_ACCUM_SATURATE_EN
    chk("ovf_out_data", 32'(bus.out_data), 255);
`else
    chk("ovf_out_data", 32'(bus.out_data), 44);
`endif
    chk("ovf_out_ovf", 32'(bus.out_ovf), 1);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;

    // len=0 goes straight to HOLD; start during result handshake is ignored
    bus.start = 1'b1; bus.len = 8'd0; tick();
    bus.start = 1'b0;
    $display("burst len=0 result data=%0d", bus.out_data);
    chk("len0_out_valid", 32'(bus.out_valid), 1);
    chk("len0_out_data",  32'(bus.out_data),  0);
    chk("len0_out_ovf",   32'(bus.out_ovf),   0);
    chk("len0_in_ready",  32'(bus.in_ready),  0);
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.len = 8'd5; tick();
    bus.out_ready = 1'b0; bus.start = 1'b0;
    chk("len0_start_ignored_busy",  32'(bus.busy),     0);
    chk("len0_start_ignored_ready", 32'(bus.in_ready), 0);

    // len=4 with in_valid gaps (junk data on idle cycles), then backpressure
    bus.start = 1'b1; bus.len = 8'd4; tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd1;  tick();
    bus.in_valid = 1'b0; bus.in_data = 8'd99; tick();
    chk("gap_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_data = 8'd2;  tick();
    bus.in_data = 8'd3; tick();
    bus.in_valid = 1'b0; bus.in_data = 8'd77; tick();
    chk("gap_no_early_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1; bus.in_data = 8'd4;  tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      $display("gap burst stall cycle %0d data=%0d valid=%0d", i, bus.out_data, bus.out_valid);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_out_data",  32'(bus.out_data),  10);
      chk("stall_out_ovf",   32'(bus.out_ovf),   0);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("stall_valid_at_handshake", 32'(bus.out_valid), 1);
    chk("stall_busy_at_handshake",  32'(bus.busy),      1);
    tick();
    bus.out_ready = 1'b0;
    chk("stall_busy_after", 32'(bus.busy),      0);
    chk("stall_valid_after", 32'(bus.out_valid), 0);

    // abort together with the 2nd of 3 operands
    bus.start = 1'b1; bus.len = 8'd3; tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd5; tick();
    bus.in_data = 8'd6; bus.abort = 1'b1; tick();
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    $display("abort issued busy=%0d", bus.busy);
    chk("abort_busy",      32'(bus.busy),      0);
    chk("abort_in_ready",  32'(bus.in_ready),  0);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    tick();
    chk("abort_out_valid_later", 32'(bus.out_valid), 0);
    bus.start = 1'b1; bus.len = 8'd1; tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd7; tick();
    bus.in_valid = 1'b0;
    $display("post-abort burst data=%0d", bus.out_data);
    chk("post_abort_valid", 32'(bus.out_valid), 1);
    chk("post_abort_data",  32'(bus.out_data),  7);
    chk("post_abort_ovf",   32'(bus.out_ovf),   0);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;

    // asynchronous reset in the middle of ACCUM
    bus.start = 1'b1; bus.len = 8'd3; tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd50; tick();
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    $display("async reset mid-burst busy=%0d", bus.busy);
    chk("arst_busy",      32'(bus.busy),      0);
    chk("arst_in_ready",  32'(bus.in_ready),  0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_out_data",  32'(bus.out_data),  0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.start = 1'b1; bus.len = 8'd2; tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd3; tick();
    bus.in_data = 8'd4; tick();
    bus.in_valid = 1'b0;
    $display("post-reset burst data=%0d", bus.out_data);
    chk("post_rst_valid", 32'(bus.out_valid), 1);
    chk("post_rst_data",  32'(bus.out_data),  7);
    chk("post_rst_ovf",   32'(bus.out_ovf),   0);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;
    chk("post_rst_idle", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
